// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU between the execute stage (port 0)
// and the auxiliary address/compute port (port 1). Round-robin grant with
// per-port credits, a tag/port tracking pipe matched to the ALU latency, and
// one result FIFO per port with valid/ready backpressure.
module alu_arbiter #(
    parameter int ALU_LAT = 1,
    parameter int RDEPTH  = 4,
    parameter int TAGW    = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [5:0]      req0_opcode,
    input  logic [5:0]      req0_funct,
    input  logic [31:0]     req0_rrs,
    input  logic [31:0]     req0_rrt,
    input  logic [15:0]     req0_imm,
    input  logic [4:0]      req0_shamt,
    input  logic [TAGW-1:0] req0_tag,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [5:0]      req1_opcode,
    input  logic [5:0]      req1_funct,
    input  logic [31:0]     req1_rrs,
    input  logic [31:0]     req1_rrt,
    input  logic [15:0]     req1_imm,
    input  logic [4:0]      req1_shamt,
    input  logic [TAGW-1:0] req1_tag,

    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [31:0]     rsp0_rslt,
    output logic [TAGW-1:0] rsp0_tag,

    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [31:0]     rsp1_rslt,
    output logic [TAGW-1:0] rsp1_tag,

    output logic [5:0]      alu_opcode,
    output logic [5:0]      alu_funct,
    output logic [31:0]     alu_rrs,
    output logic [31:0]     alu_rrt,
    output logic [15:0]     alu_imm,
    output logic [4:0]      alu_shamt,
    input  logic [31:0]     alu_rslt
);

    localparam int AW = $clog2(RDEPTH);
    localparam int PW = AW + 1;
    localparam int CW = AW + 1;
    localparam int DW = TAGW + 32;
    localparam logic [CW-1:0] CRED_MAX = CW'(RDEPTH);

    logic [1:0]            gnt;
    logic [1:0]            has_cred;
    logic [1:0]            elig;
    logic [1:0]            wr;
    logic [1:0]            pop;
    logic [1:0]            rsp_valid_v;
    logic [1:0]            rsp_ready_v;
    logic [DW-1:0]         rsp_data_v [2];
    logic [TAGW-1:0]       tag_gnt;
    logic                  last_gnt;

    logic [ALU_LAT-1:0]               pipe_vld;
    logic [ALU_LAT-1:0]               pipe_port;
    logic [ALU_LAT-1:0][TAGW-1:0]     pipe_tag;

    assign rsp_ready_v = {rsp1_ready, rsp0_ready};

    // Eligibility and round-robin grant; no grants while reset is held.
    always_comb begin
        elig[0] = req0_valid && has_cred[0] && !rst;
        elig[1] = req1_valid && has_cred[1] && !rst;
        gnt[0]  = elig[0] && (!elig[1] || last_gnt);
        gnt[1]  = elig[1] && (!elig[0] || !last_gnt);
    end

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign tag_gnt    = gnt[1] ? req1_tag : req0_tag;

    // ALU operand bus: granted request, otherwise a harmless ADDU of zeros.
    always_comb begin
        alu_opcode = 6'h00;
        alu_funct  = 6'h21;
        alu_rrs    = 32'h0;
        alu_rrt    = 32'h0;
        alu_imm    = 16'h0;
        alu_shamt  = 5'h0;
        if (gnt[0]) begin
            alu_opcode = req0_opcode;
            alu_funct  = req0_funct;
            alu_rrs    = req0_rrs;
            alu_rrt    = req0_rrt;
            alu_imm    = req0_imm;
            alu_shamt  = req0_shamt;
        end else if (gnt[1]) begin
            alu_opcode = req1_opcode;
            alu_funct  = req1_funct;
            alu_rrs    = req1_rrs;
            alu_rrt    = req1_rrt;
            alu_imm    = req1_imm;
            alu_shamt  = req1_shamt;
        end
    end

    // Remember the last granted port; reset favours port 0 on the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (|gnt) begin
            last_gnt <= gnt[1];
        end
    end

    // Tracking pipe: {valid, port, tag} walks alongside the op through the ALU.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld  <= '0;
            pipe_port <= '0;
            pipe_tag  <= '0;
        end else begin
            pipe_vld[0]  <= |gnt;
            pipe_port[0] <= gnt[1];
            pipe_tag[0]  <= tag_gnt;
            for (int i = 1; i < ALU_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_port[i] <= pipe_port[i-1];
                pipe_tag[i]  <= pipe_tag[i-1];
            end
        end
    end

    assign wr[0] = pipe_vld[ALU_LAT-1] && !pipe_port[ALU_LAT-1];
    assign wr[1] = pipe_vld[ALU_LAT-1] &&  pipe_port[ALU_LAT-1];

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [PW-1:0] wptr;
        logic [PW-1:0] rptr;
        logic [CW-1:0] cred;
        logic [DW-1:0] mem [RDEPTH];
        logic          empty;

        assign empty          = (wptr == rptr);
        assign rsp_valid_v[p] = !empty;
        assign pop[p]         = !empty && rsp_ready_v[p];
        // Credit check uses the registered count, so a pop frees a slot
        // only from the following cycle.
        assign has_cred[p]    = (cred < CRED_MAX);
        // Storage has no reset; the head is forced to zero while empty.
        assign rsp_data_v[p]  = empty ? '0 : mem[rptr[AW-1:0]];

        // FIFO pointers (with wrap bit) and credit count (in flight + queued).
        always_ff @(posedge clk) begin
            if (rst) begin
                wptr <= '0;
                rptr <= '0;
                cred <= '0;
            end else begin
                if (wr[p]) begin
                    wptr <= wptr + PW'(1);
                end
                if (pop[p]) begin
                    rptr <= rptr + PW'(1);
                end
                if (gnt[p] && !pop[p]) begin
                    cred <= cred + CW'(1);
                end else if (!gnt[p] && pop[p]) begin
                    cred <= cred - CW'(1);
                end
            end
        end

        // Result storage: capture ALU output and tag at the pipe tail.
        always_ff @(posedge clk) begin
            if (wr[p]) begin
                mem[wptr[AW-1:0]] <= {pipe_tag[ALU_LAT-1], alu_rslt};
            end
        end
    end

    assign rsp0_valid = rsp_valid_v[0];
    assign rsp0_rslt  = rsp_data_v[0][31:0];
    assign rsp0_tag   = rsp_data_v[0][DW-1:32];
    assign rsp1_valid = rsp_valid_v[1];
    assign rsp1_rslt  = rsp_data_v[1][31:0];
    assign rsp1_tag   = rsp_data_v[1][DW-1:32];

endmodule
